// File: rtl/atconv_param.sv
// Atrous-convolution engine: dilated 3x3 high-pass + bias + ReLU into layer 0, then 2x2 max-pool into layer 1.
// Latency: 10 cycles per layer-0 pixel, 5 cycles per layer-1 window, plus a 1-cycle DONE state before IDLE.
// Backpressure: none; the image and layer memories must answer combinationally in the cycle an address is presented.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (returns to IDLE, clears all outputs and the accumulator)
//   ready           start request, only looked at in IDLE
//   busy            high while a job is in flight
//   iaddr / idata   image read port (row*IMG_W+col), data captured on the closing edge of the address cycle
//   cwr, caddr_wr, cdata_wr   layer memory write port, one-cycle strobe
//   crd, caddr_rd, cdata_rd   layer memory read port (layer 0 during pooling)
//   csel            0 = layer 0 memory, 1 = layer 1 memory
//
// Build option: define ATCONV_CEIL_EN to round layer-1 values up to the next integer (saturating at 13'h1FF0).
module atconv_param #(
  parameter int          IMG_W = 64,
  parameter int          DIL   = 2,
  parameter logic [12:0] BIAS  = 13'h1FF4,
  parameter int          AW    = 2 * $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [12:0]   idata,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [12:0]   cdata_wr,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [12:0]   cdata_rd,
  output logic          csel
);

  // Coordinate width and pool-window index width. IMG_W is a power of two, so
  // row*IMG_W+col is simply {row, col}.
  localparam int CW = AW / 2;
  localparam int WW = AW - 2;

  localparam logic [AW-1:0]     PIX_LAST = '1;
  localparam logic [WW-1:0]     WIN_LAST = '1;
  localparam logic signed [16:0] BIAS_EXT = {{4{BIAS[12]}}, BIAS};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_RD,
    S_CONV_WR,
    S_POOL_RD,
    S_POOL_WR,
    S_DONE
  } state_t;

  state_t state, state_n;

  // Job counters: pix = current output pixel {row,col}, tap = kernel tap 0..8,
  // win = current pool window {r,c}, pidx = pool read 0..3.
  logic [AW-1:0]      pix, pix_n;
  logic [3:0]         tap, tap_n;
  logic [WW-1:0]      win, win_n;
  logic [1:0]         pidx, pidx_n;
  logic signed [16:0] acc, acc_n;
  logic [12:0]        pmax, pmax_n;

  // Next values of the registered outputs.
  logic               busy_n;
  logic [AW-1:0]      iaddr_n;
  logic               cwr_n;
  logic [AW-1:0]      caddr_wr_n;
  logic [12:0]        cdata_wr_n;
  logic               crd_n;
  logic [AW-1:0]      caddr_rd_n;
  logic               csel_n;

  // Combinational datapath intermediates.
  logic signed [16:0] acc_sum;
  logic signed [16:0] conv_res;
  logic [12:0]        pool_max;

  // Replicate padding: each axis is clamped independently.
  function automatic logic [CW-1:0] clamp_coord(input int v);
    if (v < 0)
      return '0;
    else if (v > IMG_W - 1)
      return CW'(IMG_W - 1);
    else
      return CW'(v);
  endfunction

  // Image address of tap k (raster order over the 3x3 dilated grid) for pixel p.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] p, input logic [3:0] k);
    int dr;
    int dc;
    case (k)
      4'd0, 4'd1, 4'd2: dr = -DIL;
      4'd3, 4'd4, 4'd5: dr = 0;
      default:          dr = DIL;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: dc = -DIL;
      4'd1, 4'd4, 4'd7: dc = 0;
      default:          dc = DIL;
    endcase
    return {clamp_coord(int'(p[AW-1:CW]) + dr), clamp_coord(int'(p[CW-1:0]) + dc)};
  endfunction

  // Kernel weight of tap k applied to pixel x; shifts are arithmetic (floor)
  // and the negation is applied after the shift.
  function automatic logic signed [16:0] tap_term(input logic [12:0] x, input logic [3:0] k);
    logic signed [16:0] xs;
    xs = {{4{x[12]}}, x};
    case (k)
      4'd0, 4'd2, 4'd6, 4'd8: tap_term = -(xs >>> 4);
      4'd1, 4'd7:             tap_term = -(xs >>> 3);
      4'd3, 4'd5:             tap_term = -(xs >>> 2);
      default:                tap_term = xs;
    endcase
  endfunction

  // ReLU with saturation to the unsigned {9,4} range.
  function automatic logic [12:0] relu_sat(input logic signed [16:0] v);
    if (v < 17'sd0)
      return 13'h0000;
    else if (v > 17'sd8191)
      return 13'h1FFF;
    else
      return v[12:0];
  endfunction

  // Layer-0 address of read i (0..3, raster order in the 2x2 block) for window w.
  function automatic logic [AW-1:0] pool_addr(input logic [WW-1:0] w, input logic [1:0] i);
    return {w[WW-1:CW-1], i[1], w[CW-2:0], i[0]};
  endfunction

`ifdef ATCONV_CEIL_EN
  // Round up to the next integer when any fraction bit is set.
  function automatic logic [12:0] ceil_l1(input logic [12:0] v);
    if (v[3:0] == 4'd0)
      return v;
    else if (v[12:4] == 9'h1FF)
      return 13'h1FF0;
    else
      return {v[12:4] + 9'd1, 4'b0000};
  endfunction
`endif

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (ready) state_n = S_CONV_RD;
      S_CONV_RD: if (tap == 4'd8) state_n = S_CONV_WR;
      S_CONV_WR: state_n = (pix == PIX_LAST) ? S_POOL_RD : S_CONV_RD;
      S_POOL_RD: if (pidx == 2'd3) state_n = S_POOL_WR;
      S_POOL_WR: state_n = (win == WIN_LAST) ? S_DONE : S_POOL_RD;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs / datapath
  // Every output is registered, so this block computes the value each output
  // takes in the state being entered on the coming edge.
  always_comb begin
    busy_n     = busy;
    iaddr_n    = iaddr;
    cwr_n      = 1'b0;
    caddr_wr_n = caddr_wr;
    cdata_wr_n = cdata_wr;
    crd_n      = 1'b0;
    caddr_rd_n = caddr_rd;
    csel_n     = csel;
    pix_n      = pix;
    tap_n      = tap;
    win_n      = win;
    pidx_n     = pidx;
    acc_n      = acc;
    pmax_n     = pmax;
    acc_sum    = '0;
    conv_res   = '0;
    pool_max   = pmax;

    case (state)
      S_IDLE: begin
        if (ready) begin
          busy_n  = 1'b1;
          pix_n   = '0;
          tap_n   = 4'd0;
          csel_n  = 1'b0;
          iaddr_n = tap_addr('0, 4'd0);
        end
      end

      S_CONV_RD: begin
        // Tap 0 restarts the sum; the last tap's product goes straight into the result.
        acc_sum  = ((tap == 4'd0) ? 17'sd0 : acc) + tap_term(idata, tap);
        acc_n    = acc_sum;
        conv_res = acc_sum + BIAS_EXT;
        if (tap == 4'd8) begin
          cwr_n      = 1'b1;
          caddr_wr_n = pix;
          cdata_wr_n = relu_sat(conv_res);
        end else begin
          tap_n   = tap + 4'd1;
          iaddr_n = tap_addr(pix, tap + 4'd1);
        end
      end

      S_CONV_WR: begin
        if (pix == PIX_LAST) begin
          win_n      = '0;
          pidx_n     = 2'd0;
          crd_n      = 1'b1;
          csel_n     = 1'b0;
          caddr_rd_n = pool_addr('0, 2'd0);
        end else begin
          pix_n   = pix + AW'(1);
          tap_n   = 4'd0;
          iaddr_n = tap_addr(pix + AW'(1), 4'd0);
        end
      end

      S_POOL_RD: begin
        pool_max = (pidx == 2'd0 || cdata_rd > pmax) ? cdata_rd : pmax;
        pmax_n   = pool_max;
        if (pidx == 2'd3) begin
          cwr_n      = 1'b1;
          csel_n     = 1'b1;
          caddr_wr_n = {2'b00, win};
`ifdef ATCONV_CEIL_EN
          cdata_wr_n = ceil_l1(pool_max);
`else
          cdata_wr_n = pool_max;
`endif
        end else begin
          crd_n      = 1'b1;
          pidx_n     = pidx + 2'd1;
          caddr_rd_n = pool_addr(win, pidx + 2'd1);
        end
      end

      S_POOL_WR: begin
        csel_n = 1'b0;
        if (win == WIN_LAST) begin
          busy_n = 1'b0;
        end else begin
          win_n      = win + WW'(1);
          pidx_n     = 2'd0;
          crd_n      = 1'b1;
          caddr_rd_n = pool_addr(win + WW'(1), 2'd0);
        end
      end

      S_DONE: begin
        busy_n = 1'b0;
      end

      default: begin
        busy_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      iaddr    <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      csel     <= 1'b0;
      pix      <= '0;
      tap      <= 4'd0;
      win      <= '0;
      pidx     <= 2'd0;
      acc      <= '0;
      pmax     <= '0;
    end else begin
      busy     <= busy_n;
      iaddr    <= iaddr_n;
      cwr      <= cwr_n;
      caddr_wr <= caddr_wr_n;
      cdata_wr <= cdata_wr_n;
      crd      <= crd_n;
      caddr_rd <= caddr_rd_n;
      csel     <= csel_n;
      pix      <= pix_n;
      tap      <= tap_n;
      win      <= win_n;
      pidx     <= pidx_n;
      acc      <= acc_n;
      pmax     <= pmax_n;
    end
  end

endmodule

// File: tb/tb_atconv_param.sv
// Bench for atconv_param: a 64x64/DIL=2 instance (impulse vectors) and an
// 8x8/DIL=1 instance (uniform image, mid-job reset, sawtooth ramp vs. a behavioural model).
// Job length is counted from the cycle ready is sampled to the first cycle busy reads low, inclusive.
module tb_atconv_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------ instance A: 64x64, DIL=2
  logic        ready_a, busy_a, cwr_a, crd_a, csel_a, clr_a;
  logic [11:0] iaddr_a, caddr_wr_a, caddr_rd_a;
  logic [12:0] idata_a, cdata_wr_a, cdata_rd_a;
  logic [12:0] img_a [4096];
  logic [12:0] l0_a  [4096];
  logic [12:0] l1_a  [1024];
  int          wr0_a, wr1_a, both_a;

  assign idata_a    = img_a[iaddr_a];
  assign cdata_rd_a = l0_a[caddr_rd_a];

  atconv_param #(.IMG_W(64), .DIL(2)) dut_a (
    .clk(clk), .reset(reset), .ready(ready_a), .busy(busy_a), .iaddr(iaddr_a), .idata(idata_a),
    .cwr(cwr_a), .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a), .crd(crd_a), .caddr_rd(caddr_rd_a),
    .cdata_rd(cdata_rd_a), .csel(csel_a));

  always @(posedge clk) begin
    if (clr_a) begin
      for (int i = 0; i < 4096; i++) l0_a[i] <= 13'h1555;
      for (int i = 0; i < 1024; i++) l1_a[i] <= 13'h1555;
      wr0_a <= 0; wr1_a <= 0; both_a <= 0;
    end else begin
      if (cwr_a) begin
        if (csel_a) begin l1_a[caddr_wr_a[9:0]] <= cdata_wr_a; wr1_a <= wr1_a + 1; end
        else        begin l0_a[caddr_wr_a]      <= cdata_wr_a; wr0_a <= wr0_a + 1; end
      end
      if (cwr_a && crd_a) both_a <= both_a + 1;
    end
  end

  // ------------------------------------------------ instance B: 8x8, DIL=1
  logic        ready_b, busy_b, cwr_b, crd_b, csel_b, clr_b;
  logic [5:0]  iaddr_b, caddr_wr_b, caddr_rd_b;
  logic [12:0] idata_b, cdata_wr_b, cdata_rd_b;
  logic [12:0] img_b [64];
  logic [12:0] l0_b  [64];
  logic [12:0] l1_b  [16];
  int          wr0_b, wr1_b, both_b;

  assign idata_b    = img_b[iaddr_b];
  assign cdata_rd_b = l0_b[caddr_rd_b];

  atconv_param #(.IMG_W(8), .DIL(1)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b), .busy(busy_b), .iaddr(iaddr_b), .idata(idata_b),
    .cwr(cwr_b), .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b), .crd(crd_b), .caddr_rd(caddr_rd_b),
    .cdata_rd(cdata_rd_b), .csel(csel_b));

  always @(posedge clk) begin
    if (clr_b) begin
      for (int i = 0; i < 64; i++) l0_b[i] <= 13'h1555;
      for (int i = 0; i < 16; i++) l1_b[i] <= 13'h1555;
      wr0_b <= 0; wr1_b <= 0; both_b <= 0;
    end else begin
      if (cwr_b) begin
        if (csel_b) begin l1_b[caddr_wr_b[3:0]] <= cdata_wr_b; wr1_b <= wr1_b + 1; end
        else        begin l0_b[caddr_wr_b]      <= cdata_wr_b; wr0_b <= wr0_b + 1; end
      end
      if (cwr_b && crd_b) both_b <= both_b + 1;
    end
  end

  // ------------------------------------------------ reference model for instance B
  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int ref_l0_b(input int r, input int c);
    int s, x;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        x = int'($signed(img_b[clampi(r + dr, 7) * 8 + clampi(c + dc, 7)]));
        if (dr != 0 && dc != 0) s -= (x >>> 4);
        else if (dr != 0)       s -= (x >>> 3);
        else if (dc != 0)       s -= (x >>> 2);
        else                    s += x;
      end
    s = s - 12;
    if (s < 0) return 0;
    if (s > 8191) return 8191;
    return s;
  endfunction

  function automatic int ref_l1_b(input int r, input int c);
    int m, v;
    m = 0;
    for (int i = 0; i < 4; i++) begin
      v = ref_l0_b(2 * r + i / 2, 2 * c + i % 2);
      if (v > m) m = v;
    end
`ifdef ATCONV_CEIL_EN
    if (m % 16 != 0) m = (m / 16 + 1) * 16;
    if (m > 16'h1FF0) m = 16'h1FF0;
`endif
    return m;
  endfunction

  // ------------------------------------------------ job runners
  task automatic run_a(output int len);
    int n;
    n = 0;
    @(negedge clk) ready_a = 1'b1;
    @(negedge clk) ready_a = 1'b0;
    check("a_first_iaddr", iaddr_a, 0);
    while (busy_a && n < 50000) begin n++; @(negedge clk); end
    check("a_finished", busy_a, 0);
    check("a_done_cwr", cwr_a, 0);
    check("a_done_crd", crd_a, 0);
    len = n + 2;
  endtask

  task automatic run_b(output int len);
    int n;
    n = 0;
    @(negedge clk) ready_b = 1'b1;
    @(negedge clk) ready_b = 1'b0;
    while (busy_b && n < 2000) begin n++; @(negedge clk); end
    check("b_finished", busy_b, 0);
    len = n + 2;
  endtask

  task automatic pulse_clr_b();
    @(negedge clk) clr_b = 1'b1;
    @(negedge clk) clr_b = 1'b0;
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    int len, nz0, nz1;
    reset = 1'b1; ready_a = 1'b0; ready_b = 1'b0; clr_a = 1'b1; clr_b = 1'b1;
    for (int i = 0; i < 4096; i++) img_a[i] = 13'h0000;
    for (int i = 0; i < 64; i++)   img_b[i] = 13'h0010;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_iaddr", iaddr_a, 0);
    check("rst_cwr", cwr_a, 0);
    check("rst_crd", crd_a, 0);
    check("rst_csel", csel_a, 0);
    reset = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    @(negedge clk);

    // ready while idle but with reset just released: nothing moves without ready
    check("idle_busy", busy_b, 0);

    // Uniform 0x0010 on 8x8: weights sum to zero, bias makes every result negative.
    pulse_clr_b();
    run_b(len);
    nz0 = 0; nz1 = 0;
    for (int i = 0; i < 64; i++) if (l0_b[i] != 13'h0000) nz0++;
    for (int i = 0; i < 16; i++) if (l1_b[i] != 13'h0000) nz1++;
    check("uni_l0_nonzero", nz0, 0);
    check("uni_l1_nonzero", nz1, 0);
    check("uni_l0_writes", wr0_b, 64);
    check("uni_l1_writes", wr1_b, 16);
    check("uni_job_len", len, 722);
    check("uni_overlap", both_b, 0);

    // Sawtooth ramp; abort at cycle 500 with a one-cycle reset, then rerun.
    for (int i = 0; i < 64; i++) img_b[i] = 13'(((i * 23) % 97) * 8 - 200);
    pulse_clr_b();
    @(negedge clk) ready_b = 1'b1;
    @(negedge clk) ready_b = 1'b0;
    repeat (499) @(negedge clk);
    check("mid_busy", busy_b, 1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("mr_busy", busy_b, 0);
    check("mr_iaddr", iaddr_b, 0);
    check("mr_cwr", cwr_b, 0);
    check("mr_caddr_wr", caddr_wr_b, 0);
    check("mr_cdata_wr", cdata_wr_b, 0);
    check("mr_crd", crd_b, 0);
    check("mr_caddr_rd", caddr_rd_b, 0);
    check("mr_csel", csel_b, 0);
    @(negedge clk);
    check("mr_stays_idle", busy_b, 0);

    pulse_clr_b();
    run_b(len);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check($sformatf("ramp_l0[%0d,%0d]", r, c), l0_b[r * 8 + c], ref_l0_b(r, c));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("ramp_l1[%0d,%0d]", r, c), l1_b[r * 4 + c], ref_l1_b(r, c));
    check("ramp_l0_writes", wr0_b, 64);
    check("ramp_l1_writes", wr1_b, 16);
    check("ramp_job_len", len, 722);
    check("ramp_overlap", both_b, 0);

    // 64x64 impulses, far enough apart not to interact:
    // +16.0 at (0,0) and (32,32), -16.0 at (16,16).
    img_a[0]           = 13'h0100;
    img_a[32 * 64 + 32] = 13'h0100;
    img_a[16 * 64 + 16] = 13'h1F00;
    @(negedge clk) clr_a = 1'b1;
    @(negedge clk) clr_a = 1'b0;
    run_a(len);
    check("imp_l0_32_32", l0_a[32 * 64 + 32], 13'h00F4);
    check("imp_l0_30_32", l0_a[30 * 64 + 32], 13'h0000);
    check("imp_l0_0_0",   l0_a[0],            13'h0084);
    check("neg_l0_16_16", l0_a[16 * 64 + 16], 13'h0000);
    check("neg_l0_14_16", l0_a[14 * 64 + 16], 13'h0014);
    check("neg_l0_16_14", l0_a[16 * 64 + 14], 13'h0034);
    check("neg_l0_14_14", l0_a[14 * 64 + 14], 13'h0004);
    check("bg_l0_40_50",  l0_a[40 * 64 + 50], 13'h0000);
`ifdef ATCONV_CEIL_EN
    check("imp_l1_16_16", l1_a[16 * 32 + 16], 13'h0100);
    check("neg_l1_7_7",   l1_a[7 * 32 + 7],   13'h0010);
    check("imp_l1_0_0",   l1_a[0],            13'h0090);
`else
    check("imp_l1_16_16", l1_a[16 * 32 + 16], 13'h00F4);
    check("neg_l1_7_7",   l1_a[7 * 32 + 7],   13'h0004);
    check("imp_l1_0_0",   l1_a[0],            13'h0084);
`endif
    check("imp_l0_writes", wr0_a, 4096);
    check("imp_l1_writes", wr1_a, 1024);
    check("imp_job_len", len, 46082);
    check("imp_overlap", both_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
